// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants and the instruction-fetch state encoding.
package legv8_pkg;
    localparam int INSTR_W    = 32;
    localparam int OPCODE_W   = 10;
    localparam int OPCODE_LSB = 22;
    localparam int PC_INC     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/ack, decode valid/ready and branch redirect.
interface instr_fetch_unit_if #(
    parameter int PC_W = 64
);
    logic                            imem_req;
    logic [PC_W-1:0]                 imem_addr;
    logic                            imem_ack;
    logic [legv8_pkg::INSTR_W-1:0]   imem_rdata;
    logic                            instr_valid;
    logic                            instr_ready;
    logic [legv8_pkg::INSTR_W-1:0]   instr;
    logic [legv8_pkg::OPCODE_W-1:0]  opcode;
    logic [PC_W-1:0]                 pc_out;
    logic                            branch_taken;
    logic [PC_W-1:0]                 branch_target;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, opcode, pc_out,
        input  instr_ready,
        input  branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, opcode, pc_out,
        output instr_ready,
        output branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC mux (hold / PC+4 / word-aligned target).
module fetch_pc_reg
    import legv8_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_target,
    input  logic            increment,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // A redirect always wins over the sequential increment; the add wraps silently.
    always_comb begin
        pc_d = pc_q;
        if (load_target) begin
            pc_d = target & ~PC_W'(3);
        end else if (increment) begin
            pc_d = pc_q + PC_W'(PC_INC);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;
endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential LEGv8 instruction fetch: IDLE/REQ/HOLD FSM, flush tracking and decode-side output registers.
module instr_fetch_unit
    import legv8_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    instr_fetch_unit_if.master  bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_HOLD = HOLD;

    logic [1:0]         state_q, state_d;
    logic               flush_q, flush_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic [PC_W-1:0]    pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_next;
    logic               accept;
    logic               pc_inc;

    assign accept = (state_q == ST_HOLD) && bus.instr_ready;
    assign pc_inc = accept && !bus.branch_taken;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_target (bus.branch_taken),
        .increment   (pc_inc),
        .target      (bus.branch_target),
        .pc          (pc),
        .pc_next     (pc_next)
    );

    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        // The request address is frozen while a request is outstanding, even if the PC is redirected.
        addr_d   = (state_q == ST_REQ && !bus.imem_ack) ? addr_q : pc_next;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    flush_d = 1'b0;
                    if (flush_q || bus.branch_taken) begin
                        state_d = ST_REQ;
                    end else begin
                        instr_d  = bus.imem_rdata;
                        pc_out_d = pc;
                        state_d  = ST_HOLD;
                    end
                end else if (bus.branch_taken) begin
                    flush_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d = run ? ST_REQ : ST_IDLE;
                end else if (bus.branch_taken) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            flush_q  <= 1'b0;
            addr_q   <= RESET_PC;
            pc_out_q <= RESET_PC;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            addr_q   <= addr_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
        end
    end

    assign bus.imem_req    = (state_q == ST_REQ);
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = (state_q == ST_HOLD);
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[OPCODE_LSB +: OPCODE_W];
    assign bus.pc_out      = pc_out_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a transaction-level reference model checked every cycle.
module tb_instr_fetch_unit;
    localparam int          PC_W     = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic clk = 1'b0;
    logic rst_n;
    logic run;

    int n_checks = 0;
    int n_fail   = 0;

    int mem_lat  = 0;
    bit spurious = 1'b0;
    int wait_cnt = 0;

    logic [63:0] acc_log[$];

    instr_fetch_unit_if #(.PC_W(PC_W)) bus ();

    instr_fetch_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Program image: address 0 holds the first instruction from the test plan.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h8B02_0020;
        return a[63:32] ^ a[31:0] ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (bus.instr_valid !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk(name, {63'd0, bus.instr_valid}, 64'd1);
    endtask

    // Memory responder: ack after mem_lat wait cycles; optional ack without a request.
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.imem_req === 1'b1 && wait_cnt >= mem_lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
                wait_cnt       = 0;
            end else begin
                bus.imem_ack   = spurious && (bus.imem_req !== 1'b1);
                bus.imem_rdata = 32'hFFFF_FFFF;
                wait_cnt       = (bus.imem_req === 1'b1) ? wait_cnt + 1 : 0;
            end
        end
    end

    // Reference model: architectural PC plus protocol expectations, checked on every falling edge.
    initial begin
        logic [63:0] m_pc;
        logic        m_stale, m_after_reset;
        logic        p_req, p_ack, p_valid, p_accept, p_branch, p_run, p_drop, p_deliver;
        logic [63:0] p_addr;
        logic        exp_req, exp_valid, accept, hold_cont;
        logic [31:0] exp_instr;
        m_pc = RESET_PC; m_stale = 1'b0; m_after_reset = 1'b1;
        p_req = 0; p_ack = 0; p_valid = 0; p_accept = 0; p_branch = 0;
        p_run = 0; p_drop = 0; p_deliver = 0; p_addr = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                m_pc          = RESET_PC;
                m_stale       = 1'b0;
                m_after_reset = 1'b1;
            end else begin
                if (m_after_reset) begin
                    chk("rst_imem_req", {63'd0, bus.imem_req}, 64'd0);
                    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
                    chk("rst_instr_valid", {63'd0, bus.instr_valid}, 64'd0);
                    chk("rst_instr", {32'd0, bus.instr}, 64'd0);
                    chk("rst_opcode", {54'd0, bus.opcode}, 64'd0);
                    chk("rst_pc_out", bus.pc_out, RESET_PC);
                end else begin
                    if (p_req) exp_req = p_ack ? p_drop : 1'b1;
                    else if (p_valid) exp_req = p_accept ? p_run : p_branch;
                    else exp_req = p_run;
                    chk("imem_req", {63'd0, bus.imem_req}, {63'd0, exp_req});
                    if (p_req && !p_ack) chk("imem_addr_stable", bus.imem_addr, p_addr);
                    else if (bus.imem_req === 1'b1) chk("imem_addr_new", bus.imem_addr, m_pc);
                    hold_cont = p_valid && !p_accept && !p_branch;
                    exp_valid = hold_cont || p_deliver;
                    chk("instr_valid", {63'd0, bus.instr_valid}, {63'd0, exp_valid});
                    if (bus.instr_valid === 1'b1) begin
                        exp_instr = mem_word(m_pc);
                        chk("pc_out", bus.pc_out, m_pc);
                        chk("instr", {32'd0, bus.instr}, {32'd0, exp_instr});
                        chk("opcode", {54'd0, bus.opcode}, {54'd0, exp_instr[31:22]});
                    end
                end
                accept    = (bus.instr_valid === 1'b1) && (bus.instr_ready === 1'b1);
                p_deliver = bus.imem_req && bus.imem_ack && !bus.branch_taken && !m_stale;
                p_drop    = bus.imem_req && bus.imem_ack && (bus.branch_taken || m_stale);
                if (bus.imem_req && bus.imem_ack) m_stale = 1'b0;
                else if (bus.imem_req && bus.branch_taken) m_stale = 1'b1;
                if (accept) acc_log.push_back(bus.pc_out);
                if (bus.branch_taken) m_pc = bus.branch_target & ~64'd3;
                else if (accept) m_pc = m_pc + 64'd4;
                p_req    = bus.imem_req;
                p_ack    = bus.imem_ack;
                p_addr   = bus.imem_addr;
                p_valid  = bus.instr_valid;
                p_accept = accept;
                p_branch = bus.branch_taken;
                p_run    = run;
                m_after_reset = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        rst_n = 1'b0; run = 1'b0;
        bus.instr_ready = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset and first fetch from zero-wait memory.
        run = 1'b1;
        step();
        chk("first_req", {63'd0, bus.imem_req}, 64'd1);
        chk("first_addr", bus.imem_addr, 64'h0);
        chk("first_not_valid_yet", {63'd0, bus.instr_valid}, 64'd0);
        step();
        chk("first_valid", {63'd0, bus.instr_valid}, 64'd1);
        chk("first_instr", {32'd0, bus.instr}, 64'h8B02_0020);
        chk("first_opcode", {54'd0, bus.opcode}, {54'd0, 10'b1000101100});
        chk("first_pc_out", bus.pc_out, 64'h0);

        // Sequential fetch with ready held high, then a 5-cycle stall.
        bus.instr_ready = 1'b1;
        k = 0;
        while (acc_log.size() < 3 && k < 50) begin step(); k++; end
        bus.instr_ready = 1'b0;
        chk("seq_count", 64'(acc_log.size()), 64'd3);
        if (acc_log.size() >= 3) begin
            chk("seq_addr0", acc_log[0], 64'h0);
            chk("seq_addr1", acc_log[1], 64'h4);
            chk("seq_addr2", acc_log[2], 64'h8);
        end
        wait_valid("stall_valid");
        for (int i = 0; i < 5; i++) begin
            chk("stall_no_req", {63'd0, bus.imem_req}, 64'd0);
            chk("stall_pc_out", bus.pc_out, 64'hC);
            step();
        end

        // Three wait states: request visible for four cycles.
        mem_lat = 3;
        bus.instr_ready = 1'b1;
        step();
        n = 0; k = 0;
        while (bus.instr_valid !== 1'b1 && k < 20) begin
            if (bus.imem_req === 1'b1) n++;
            step(); k++;
        end
        bus.instr_ready = 1'b0;
        chk("wait_req_cycles", 64'(n), 64'd4);
        chk("wait_pc_out", bus.pc_out, 64'h10);

        // Branch together with accept: misaligned target is forced to a word address.
        bus.instr_ready = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 64'h103;
        step();
        bus.instr_ready = 1'b0; bus.branch_taken = 1'b0;
        chk("br_accept_req", {63'd0, bus.imem_req}, 64'd1);
        chk("br_accept_addr", bus.imem_addr, 64'h100);
        wait_valid("br_accept_valid");
        chk("br_accept_pc_out", bus.pc_out, 64'h100);

        // Branch in HOLD squashes, then a second branch while the request at 8 is outstanding.
        bus.branch_taken = 1'b1; bus.branch_target = 64'h8;
        step();
        bus.branch_taken = 1'b0;
        chk("squash_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("squash_addr", bus.imem_addr, 64'h8);
        step();
        bus.branch_taken = 1'b1; bus.branch_target = 64'h40;
        step();
        bus.branch_taken = 1'b0;
        wait_valid("flush_valid");
        chk("flush_pc_out", bus.pc_out, 64'h40);

        // Branch in the same cycle as the memory ack.
        mem_lat = 2;
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        k = 0;
        while (bus.imem_ack !== 1'b1 && k < 10) begin step(); k++; end
        bus.branch_taken = 1'b1; bus.branch_target = 64'h80;
        step();
        bus.branch_taken = 1'b0;
        chk("ackbr_req", {63'd0, bus.imem_req}, 64'd1);
        chk("ackbr_addr", bus.imem_addr, 64'h80);
        chk("ackbr_valid", {63'd0, bus.instr_valid}, 64'd0);
        wait_valid("ackbr_valid_later");
        chk("ackbr_pc_out", bus.pc_out, 64'h80);

        // Drop run on accept, then stray acks while idle.
        run = 1'b0; bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("idle_req", {63'd0, bus.imem_req}, 64'd0);
        spurious = 1'b1;
        repeat (3) step();
        spurious = 1'b0;
        chk("idle_stray_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("idle_stray_req", {63'd0, bus.imem_req}, 64'd0);

        // Wrap: top word of the address space, then PC+4 rolls to zero.
        mem_lat = 0;
        run = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        bus.branch_taken = 1'b0;
        chk("wrap_req", {63'd0, bus.imem_req}, 64'd1);
        chk("wrap_addr_top", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_pc_out", bus.pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        mem_lat = 3;
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("wrap_addr_zero", bus.imem_addr, 64'h0);

        // Reset while a request is outstanding.
        rst_n = 1'b0;
        step();
        chk("midrst_req", {63'd0, bus.imem_req}, 64'd0);
        chk("midrst_valid", {63'd0, bus.instr_valid}, 64'd0);
        rst_n = 1'b1; mem_lat = 0;
        step();
        chk("refetch_req", {63'd0, bus.imem_req}, 64'd1);
        chk("refetch_addr", bus.imem_addr, RESET_PC);
        wait_valid("refetch_valid");
        chk("refetch_instr", {32'd0, bus.instr}, 64'h8B02_0020);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0; run = 1'b0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
